// File: rtl/bullet_engine.sv
// ---------------------------------------------------------------------------
// bullet_engine
//   Frame-stepped bullet pool for the two-tank game. Each player owns SLOTS
//   bullet slots. On every vsync rising edge the engine sweeps all slots
//   (one per cycle) and moves or retires live bullets. It then runs one spawn
//   cycle per player, which honours that player's fire request and cooldown.
//
// Ports:
//   CLK           system clock
//   RESET         asynchronous, active-low reset
//   vs            raw VGA vsync; its rising edge starts a frame update
//   fire[p]       fire request for player p (level)
//   tank_x/y[p]   tank centre of player p, used as the spawn position
//   turret_dir[p] 0=up, clockwise in 45 degree steps up to 7=up-left
//   bullet_array  [player][slot] words: {8'b0, dir[2:0], y[9:0], x[9:0], valid}
//   busy          high during the SWEEP and SPAWN cycles of an update
//   frame_done    one-cycle pulse after the last spawn cycle
// ---------------------------------------------------------------------------

// Moves one slot word by SPEED along its direction. A bullet that would leave
// the screen is returned as an all-zero word.
module bullet_step #(
    parameter int SPEED    = 4,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);
    localparam logic signed [11:0] SPD  = 12'(SPEED);
    localparam logic signed [11:0] XLIM = 12'(SCREEN_W);
    localparam logic signed [11:0] YLIM = 12'(SCREEN_H);

    logic signed [11:0] dx, dy, nx, ny;
    logic               off;

    always_comb begin
        dx = '0;
        dy = '0;
        // Screen y grows downwards, so "up" is a negative dy.
        case (word_i[23:21])
            3'd0:    dy = -SPD;
            3'd1:    begin dx =  SPD; dy = -SPD; end
            3'd2:    dx =  SPD;
            3'd3:    begin dx =  SPD; dy =  SPD; end
            3'd4:    dy =  SPD;
            3'd5:    begin dx = -SPD; dy =  SPD; end
            3'd6:    dx = -SPD;
            default: begin dx = -SPD; dy = -SPD; end
        endcase
        // The extra headroom bits keep a 10-bit coordinate plus SPEED from
        // wrapping back onto the screen.
        nx = $signed({2'b00, word_i[10:1]}) + dx;
        ny = $signed({2'b00, word_i[20:11]}) + dy;
        off = nx[11] | ny[11] | (nx >= XLIM) | (ny >= YLIM);
        word_o = off ? '0 : {word_i[31:21], ny[9:0], nx[9:0], word_i[0]};
    end
endmodule

module bullet_engine #(
    parameter int SLOTS    = 8,
    parameter int SPEED    = 4,
    parameter int COOLDOWN = 8,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         vs,
    input  logic [1:0]                   fire,
    input  logic [1:0][9:0]              tank_x,
    input  logic [1:0][9:0]              tank_y,
    input  logic [1:0][2:0]              turret_dir,
    output logic [1:0][SLOTS-1:0][31:0]  bullet_array,
    output logic                         busy,
    output logic                         frame_done
);
    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    // The +2 keeps the width at one bit or more even when COOLDOWN is 0.
    localparam int CW = $clog2(COOLDOWN + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_SWEEP, S_SPAWN0, S_SPAWN1, S_DONE
    } state_t;

    state_t                       state_q, state_d;
    logic                         vs_q;
    logic [SW-1:0]                slot_q, slot_d;
    logic                         player_q, player_d;
    logic [1:0][CW-1:0]           cd_q, cd_d;
    logic [1:0][SLOTS-1:0][31:0]  bullets_q, bullets_d;

    logic                         tick;
    logic                         slot_last;
    logic [31:0]                  cur_word, moved_word;
    logic                         sp;
    logic                         free_found;
    logic [SW-1:0]                free_idx;

    assign tick      = vs & ~vs_q;
    assign slot_last = (slot_q == SW'(SLOTS - 1));
    assign cur_word  = bullets_q[player_q][slot_q];
    assign sp        = (state_q == S_SPAWN1);

    bullet_step #(
        .SPEED    (SPEED),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_step (
        .word_i (cur_word),
        .word_o (moved_word)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (tick) state_d = S_SWEEP;
            S_SWEEP:  if (player_q && slot_last) state_d = S_SPAWN0;
            S_SPAWN0: state_d = S_SPAWN1;
            S_SPAWN1: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            S_SWEEP, S_SPAWN0, S_SPAWN1: busy = 1'b1;
            S_DONE:                      frame_done = 1'b1;
            default: ;
        endcase
    end

    // Lowest-index free slot of the player being spawned. Scanning downwards
    // lets the last hit (the lowest index) win.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!bullets_q[sp][i][0]) begin
                free_found = 1'b1;
                free_idx   = SW'(i);
            end
        end
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        bullets_d = bullets_q;
        cd_d      = cd_q;
        slot_d    = slot_q;
        player_d  = player_q;
        case (state_q)
            S_IDLE: begin
                slot_d   = '0;
                player_d = 1'b0;
            end
            S_SWEEP: begin
                if (cur_word[0]) bullets_d[player_q][slot_q] = moved_word;
                if (slot_last) begin
                    slot_d   = '0;
                    player_d = ~player_q;
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            S_SPAWN0, S_SPAWN1: begin
                if (cd_q[sp] != '0) begin
                    cd_d[sp] = cd_q[sp] - 1'b1;
                end else if (fire[sp] && free_found) begin
                    // A full pool drops the request and leaves the cooldown at 0.
                    bullets_d[sp][free_idx] = {8'd0, turret_dir[sp], tank_y[sp],
                                               tank_x[sp], 1'b1};
                    cd_d[sp] = CW'(COOLDOWN);
                end
            end
            default: ;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            vs_q      <= 1'b1;   // a vs held high through reset is not an edge
            slot_q    <= '0;
            player_q  <= 1'b0;
            cd_q      <= '0;
            bullets_q <= '0;
        end else begin
            vs_q      <= vs;
            slot_q    <= slot_d;
            player_q  <= player_d;
            cd_q      <= cd_d;
            bullets_q <= bullets_d;
        end
    end

    assign bullet_array = bullets_q;
endmodule

// File: tb/tb_bullet_engine.sv
module tb_bullet_engine;
    logic CLK = 1'b0;
    logic RESET = 1'b0;
    logic vs = 1'b1;
    logic [1:0] fire = '0;
    logic [1:0][9:0] tank_x = '0, tank_y = '0;
    logic [1:0][2:0] turret_dir = '0;
    logic [1:0][7:0][31:0] ba0, ba1;
    logic busy0, busy1, fd0, fd1;
    logic busy_mid;

    int checks = 0;
    int errors = 0;

    always #10 CLK = ~CLK;

    // dut: default cooldown of 8; dut_nc: no cooldown
    bullet_engine #(.SLOTS(8), .SPEED(4), .COOLDOWN(8)) dut (
        .CLK(CLK), .RESET(RESET), .vs(vs), .fire(fire), .tank_x(tank_x),
        .tank_y(tank_y), .turret_dir(turret_dir), .bullet_array(ba0),
        .busy(busy0), .frame_done(fd0));

    bullet_engine #(.SLOTS(8), .SPEED(4), .COOLDOWN(0)) dut_nc (
        .CLK(CLK), .RESET(RESET), .vs(vs), .fire(fire), .tank_x(tank_x),
        .tank_y(tank_y), .turret_dir(turret_dir), .bullet_array(ba1),
        .busy(busy1), .frame_done(fd1));

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mkw(int x, int y, int d);
        return 32'(1 | (x << 1) | (y << 11) | (d << 21));
    endfunction

    // ---------------- reference model ----------------
    int dxt[8] = '{0, 4, 4, 4, 0, -4, -4, -4};
    int dyt[8] = '{-4, -4, 0, 4, 4, 4, 0, -4};
    int cdpar[2] = '{8, 0};
    bit mv[2][2][8];
    int mx[2][2][8], my[2][2][8], md[2][2][8];
    int mcd[2][2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int p = 0; p < 2; p++) begin
                mcd[m][p] = 0;
                for (int s = 0; s < 8; s++) begin
                    mv[m][p][s] = 0; mx[m][p][s] = 0; my[m][p][s] = 0; md[m][p][s] = 0;
                end
            end
        end
    endtask

    task automatic model_frame(int m);
        for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < 8; s++) begin
                if (mv[m][p][s]) begin
                    int nx, ny;
                    nx = mx[m][p][s] + dxt[md[m][p][s]];
                    ny = my[m][p][s] + dyt[md[m][p][s]];
                    if (nx < 0 || nx >= 640 || ny < 0 || ny >= 480) begin
                        mv[m][p][s] = 0; mx[m][p][s] = 0; my[m][p][s] = 0; md[m][p][s] = 0;
                    end else begin
                        mx[m][p][s] = nx; my[m][p][s] = ny;
                    end
                end
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (mcd[m][p] != 0) begin
                mcd[m][p]--;
            end else if (fire[p]) begin
                int slot;
                slot = -1;
                for (int s = 7; s >= 0; s--) if (!mv[m][p][s]) slot = s;
                if (slot >= 0) begin
                    mv[m][p][slot] = 1;
                    mx[m][p][slot] = int'(tank_x[p]);
                    my[m][p][slot] = int'(tank_y[p]);
                    md[m][p][slot] = int'(turret_dir[p]);
                    mcd[m][p] = cdpar[m];
                end
            end
        end
    endtask

    task automatic check_model(int frame);
        for (int m = 0; m < 2; m++)
            for (int p = 0; p < 2; p++)
                for (int s = 0; s < 8; s++) begin
                    logic [31:0] exp, act;
                    exp = mv[m][p][s] ? mkw(mx[m][p][s], my[m][p][s], md[m][p][s]) : 32'd0;
                    act = (m == 0) ? ba0[p][s] : ba1[p][s];
                    chk($sformatf("rand f%0d dut%0d p%0d s%0d", frame, m, p, s), act, exp);
                end
    endtask

    // ---------------- stimulus helpers ----------------
    // Cycle 1 is the edge-detect cycle in which vs rises; the return value is
    // the index of the cycle in which frame_done is high.
    task automatic run_frame(output int cyc);
        vs = 1'b0;
        repeat (2) @(posedge CLK);
        #1 vs = 1'b1;
        cyc = 1;
        busy_mid = 1'b0;
        while (!fd0 && cyc < 100) begin
            @(posedge CLK); #1;
            cyc++;
            if (cyc == 5) busy_mid = busy0;
        end
        chk("frame_done_seen", {31'd0, fd0}, 32'd1);
    endtask

    task automatic do_reset();
        @(posedge CLK); #1 RESET = 1'b0;
        @(posedge CLK); #1 RESET = 1'b1;
    endtask

    typedef struct {
        logic [1:0] fire;
        int tx, ty, dir;
        logic [31:0] e0, e1;
    } vec_t;
    vec_t tv[7];

    initial begin
        int cyc, n;

        // ---- reset state ----
        repeat (3) @(posedge CLK);
        #1;
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < 8; s++) chk($sformatf("reset word p%0d s%0d", p, s), ba0[p][s], 32'd0);
        chk("reset busy", {31'd0, busy0}, 32'd0);
        chk("reset frame_done", {31'd0, fd0}, 32'd0);
        RESET = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin @(posedge CLK); #1; if (fd0) n++; end
        chk("no update with vs held high", n, 0);

        // ---- directed table (checked on the no-cooldown instance) ----
        tv[0] = '{2'b01, 100, 200, 2, 32'h004640C9,       32'd0};
        tv[1] = '{2'b00, 100, 200, 2, mkw(104, 200, 2),   32'd0};
        tv[2] = '{2'b01, 638,  10, 1, mkw(108, 200, 2),   mkw(638, 10, 1)};
        tv[3] = '{2'b00, 638,  10, 1, mkw(112, 200, 2),   32'd0};
        tv[4] = '{2'b01,   4,   4, 7, mkw(116, 200, 2),   mkw(4, 4, 7)};
        tv[5] = '{2'b00,   4,   4, 7, mkw(120, 200, 2),   mkw(0, 0, 7)};
        tv[6] = '{2'b00,   4,   4, 7, mkw(124, 200, 2),   32'd0};
        for (int i = 0; i < 7; i++) begin
            fire = tv[i].fire;
            tank_x[0] = 10'(tv[i].tx); tank_y[0] = 10'(tv[i].ty);
            turret_dir[0] = 3'(tv[i].dir);
            run_frame(cyc);
            if (i == 0) begin
                chk("frame_done cycle", cyc, 20);
                chk("busy mid-update", {31'd0, busy_mid}, 32'd1);
                chk("busy low in done", {31'd0, busy0}, 32'd0);
                chk("frame_done both", {31'd0, fd1}, 32'd1);
                @(posedge CLK); #1;
                chk("frame_done one cycle", {31'd0, fd0}, 32'd0);
            end
            chk($sformatf("vec%0d p0 s0", i), ba1[0][0], tv[i].e0);
            chk($sformatf("vec%0d p0 s1", i), ba1[0][1], tv[i].e1);
            chk($sformatf("vec%0d p0 s2", i), ba1[0][2], 32'd0);
            chk($sformatf("vec%0d p1 s0", i), ba1[1][0], 32'd0);
        end

        // ---- pool full ----
        do_reset();
        fire = 2'b01; tank_x[0] = 10'd300; tank_y[0] = 10'd400; turret_dir[0] = 3'd0;
        for (int f = 1; f <= 9; f++) begin
            run_frame(cyc);
            if (f >= 8)
                for (int j = 0; j < 8; j++)
                    chk($sformatf("pool f%0d s%0d", f, j), ba1[0][j], mkw(300, 400 - 4 * (f - 1 - j), 0));
        end
        chk("pool cooldown s0", ba0[0][0], mkw(300, 368, 0));
        chk("pool cooldown s1", ba0[0][1], 32'd0);

        // ---- cooldown, both players firing ----
        do_reset();
        fire = 2'b11;
        tank_x[0] = 10'd100; tank_y[0] = 10'd100; turret_dir[0] = 3'd2;
        tank_x[1] = 10'd200; tank_y[1] = 10'd300; turret_dir[1] = 3'd6;
        for (int f = 0; f <= 18; f++) begin
            run_frame(cyc);
            for (int p = 0; p < 2; p++) begin
                n = 0;
                for (int s = 0; s < 8; s++) n += int'(ba0[p][s][0]);
                chk($sformatf("cooldown f%0d p%0d count", f, p), n, f / 9 + 1);
            end
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("cooldown p0 s%0d", k), ba0[0][k], mkw(100 + 4 * (18 - 9 * k), 100, 2));
            chk($sformatf("cooldown p1 s%0d", k), ba0[1][k], mkw(200 - 4 * (18 - 9 * k), 300, 6));
        end
        chk("cooldown p0 s3", ba0[0][3], 32'd0);

        // ---- reset in the middle of a sweep ----
        fire = 2'b00;
        vs = 1'b0;
        repeat (2) @(posedge CLK);
        #1 vs = 1'b1;
        @(posedge CLK);
        repeat (5) @(posedge CLK);
        #1 RESET = 1'b0;
        #1;
        n = 0;
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < 8; s++) n += (ba0[p][s] != 0) ? 1 : 0;
        chk("mid reset words cleared", n, 0);
        chk("mid reset busy", {31'd0, busy0}, 32'd0);
        chk("mid reset frame_done", {31'd0, fd0}, 32'd0);
        @(posedge CLK); #1 RESET = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin @(posedge CLK); #1; if (fd0) n++; end
        chk("no update after mid reset", n, 0);
        vs = 1'b0;
        repeat (2) @(posedge CLK);
        #1 vs = 1'b1;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge CLK); #1;
            if (fd0) n++;
            if (i == 5) vs = 1'b0;
            if (i == 7) begin
                vs = 1'b1;
                chk("busy when vs edge arrives", {31'd0, busy0}, 32'd1);
            end
        end
        chk("vs edge while busy ignored", n, 1);

        // ---- randomized frames against the model ----
        do_reset();
        model_reset();
        for (int f = 0; f < 40; f++) begin
            fire = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 3) == 0) begin
                    tank_x[p] = 10'($urandom_range(0, 1) ? $urandom_range(0, 6) : $urandom_range(633, 639));
                    tank_y[p] = 10'($urandom_range(0, 1) ? $urandom_range(0, 6) : $urandom_range(473, 479));
                end else begin
                    tank_x[p] = 10'($urandom_range(0, 639));
                    tank_y[p] = 10'($urandom_range(0, 479));
                end
                turret_dir[p] = 3'($urandom_range(0, 7));
            end
            run_frame(cyc);
            model_frame(0);
            model_frame(1);
            check_model(f);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
